// File: rtl/avr_dmem.sv
// Data-memory responder for the AVR data bus: decodes alias / I/O / SRAM / unmapped
// regions, answers reads with one-cycle latency and forwards I/O accesses.
module avr_dmem #(
  parameter logic [15:0] IO_BASE    = 16'h0020,
  parameter int          IO_SIZE    = 64,
  parameter logic [15:0] SRAM_BASE  = 16'h0060,
  parameter int          SRAM_DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] d_addr,
  input  logic        data_write,
  inout  wire  [7:0]  data,
  output logic [5:0]  io_addr,
  output logic [7:0]  io_wdata,
  output logic        io_we,
  output logic        io_re,
  input  logic [7:0]  io_rdata,
  output logic        bad_access,
  output logic [15:0] bad_addr
);

  localparam int AW = $clog2(SRAM_DEPTH);

  // Bounds are kept 17 bits wide so the window ends never wrap back into low memory.
  localparam logic [16:0] IO_LO   = {1'b0, IO_BASE};
  localparam logic [16:0] IO_HI   = IO_LO + 17'(IO_SIZE);
  localparam logic [16:0] SRAM_LO = {1'b0, SRAM_BASE};
  localparam logic [16:0] SRAM_HI = SRAM_LO + 17'(SRAM_DEPTH);

  typedef enum logic [1:0] {
    REG_ALIAS,
    REG_IO,
    REG_SRAM,
    REG_NONE
  } region_t;

  region_t        region;
  logic [16:0]    addr_x;
  logic [AW-1:0]  sram_idx;
  logic [7:0]     rd_mux;
  logic [7:0]     rdata_q;
  logic [7:0]     mem [SRAM_DEPTH];

  assign addr_x   = {1'b0, d_addr};
  assign sram_idx = AW'(d_addr - SRAM_BASE);

  always_comb begin
    region = REG_NONE;
    if (addr_x < IO_LO)
      region = REG_ALIAS;
    else if (addr_x < IO_HI)
      region = REG_IO;
    else if (addr_x >= SRAM_LO && addr_x < SRAM_HI)
      region = REG_SRAM;
  end

  assign io_addr  = 6'(d_addr - IO_BASE);
  assign io_wdata = data;
  assign io_we    = !RST &&  data_write && (region == REG_IO);
  assign io_re    = !RST && !data_write && (region == REG_IO);

  assign data = data_write ? 8'hzz : rdata_q;

  always_comb begin
    rd_mux = 8'hFF;
    unique case (region)
      REG_ALIAS: rd_mux = 8'h00;
      REG_IO:    rd_mux = io_rdata;
      REG_SRAM:  rd_mux = mem[sram_idx];
      REG_NONE:  rd_mux = 8'hFF;
    endcase
  end

  // SRAM contents survive reset; only the write itself is blocked while RST is high.
  always_ff @(posedge CLK) begin
    if (!RST && data_write && region == REG_SRAM)
      mem[sram_idx] <= data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_q    <= 8'h00;
      bad_access <= 1'b0;
      bad_addr   <= 16'h0000;
    end else begin
      if (!data_write)
        rdata_q <= rd_mux;
      if (region == REG_NONE) begin
        bad_access <= 1'b1;
        if (!bad_access)
          bad_addr <= d_addr;
      end
    end
  end

endmodule

// File: doc/avr_dmem.md
Name: avr_dmem

Overview:
Data-memory responder for the AVR core's data bus. The core initiates accesses with d_addr, data_write and the bidirectional 8-bit data bus; this block answers them. It decodes each address into one of four regions: register alias, I/O window (forwarded to a peripheral port), internal SRAM, or unmapped. It returns read data one cycle after the address is presented, which is the timing the core's POP and RET hold states rely on.

Parameters:
IO_BASE, 16'h0020, first address of the I/O window.
IO_SIZE, 64, number of bytes in the I/O window.
SRAM_BASE, 16'h0060, first SRAM address.
SRAM_DEPTH, 1024, SRAM bytes; the RTL supports any power of two from 64 to 4096.

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
d_addr  in  16  data address from the core
data_write  in  1  core drives data this cycle; write strobe
data  inout  8  shared bus; core drives when data_write=1, this block drives otherwise
io_addr  out  6  d_addr - IO_BASE (combinational)
io_wdata  out  8  write data to peripherals (equals data)
io_we  out  1  I/O write strobe (combinational, same cycle)
io_re  out  1  I/O read strobe (combinational, same cycle)
io_rdata  in  8  peripheral read data, valid in the cycle io_re is high
bad_access  out  1  sticky flag: any access to an unmapped address
bad_addr  out  16  address of the first unmapped access since reset

Behaviour:
- Region decode, combinational on d_addr:
  - ALIAS: d_addr < IO_BASE.
  - IO: IO_BASE <= d_addr < IO_BASE+IO_SIZE.
  - SRAM: SRAM_BASE <= d_addr < SRAM_BASE+SRAM_DEPTH.
  - UNMAPPED: everything else.
- Every cycle is an access. Write when data_write=1; otherwise read. There is no idle state; the core parks d_addr on SP.
- Bus drive: data = data_write ? 8'bz : rdata_q. The block never drives while data_write=1.
- Reads have one-cycle latency. At posedge, rdata_q is loaded from the region read in that cycle:
  - ALIAS: 8'h00.
  - IO: io_rdata.
  - SRAM: mem[d_addr - SRAM_BASE].
  - UNMAPPED: 8'hFF.
- Write cycles:
  - rdata_q holds its previous value.
  - SRAM: mem[d_addr - SRAM_BASE] <= data at posedge.
  - IO: io_we=1 for that cycle only.
  - ALIAS and UNMAPPED: write is dropped. The register file lives in the core.
- io_re=1 only on a read cycle in IO. io_we=1 only on a write cycle in IO. The two are never high together.
- Read-after-write: a write to A in cycle N followed by a read of A in cycle N+1 returns the new value at cycle N+2. There is no write-to-read bypass within a single cycle; a single cycle cannot both read and write.
- Back-to-back reads are fully pipelined. The address in cycle N yields data in cycle N+1, with no bubbles.
- Unmapped accesses (read or write): bad_access <= 1, sticky. If bad_access was 0, bad_addr <= d_addr. Later bad accesses do not update bad_addr.
- Address arithmetic: offsets are computed with 16-bit unsigned subtraction and are used only inside their decoded region. No wrap-around aliasing; 16'hFFFF is UNMAPPED with the default parameters.
- Reset (synchronous, RST=1 at posedge):
  - rdata_q=8'h00, bad_access=0, bad_addr=16'h0000.
  - SRAM contents are not cleared.
  - While RST=1, io_we=0 and io_re=0, and any SRAM write is suppressed.
  - Reset mid-burst discards the pending read; the first cycle after reset shows 8'h00.
- The SRAM is inferred as single-port synchronous RAM (one read or one write per cycle).

Test Plan:
- Reset: hold RST for 2 cycles with data_write=1 at 16'h0100 → no SRAM change. After reset, data=8'h00, bad_access=0, bad_addr=16'h0000.
- SRAM write then read: write 8'hA5 to 16'h0100, then read 16'h0100 → data=8'hA5 in the following cycle. A back-to-back read stream over 16'h0060..16'h0063 returns the previously written 8'h11..8'h44 with 1-cycle latency and no gaps.
- Push/pop order: write 8'h12 @16'h045F, write 8'h34 @16'h045E, then read 16'h045F and 16'h045E → 8'h12 then 8'h34. This is the RCALL/RET byte order.
- I/O forwarding: write 8'h5A to 16'h0053 → io_we=1, io_addr=6'h33, io_wdata=8'h5A for exactly 1 cycle. Read 16'h0035 with io_rdata=8'hC3 → io_re=1 and io_addr=6'h15 that cycle; data=8'hC3 next cycle.
- Alias and unmapped: read 16'h001F → 8'h00. Write 16'h0500, then read 16'hFFFF → the read returns 8'hFF, bad_access=1, bad_addr=16'h0500 (first bad address retained). An SRAM read afterwards is unaffected.
- Bus contention: whenever data_write=1, the block's data driver is z; check this over a random 1000-cycle read/write mix, with a scoreboard model comparing every read.
